// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial NOR adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/fa_nor.sv
// One-bit full adder built purely from 2-input NOR gates.
// Latency: combinational.
// Backpressure: none.
module fa_nor (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic carry
);

  logic n1, n2, n3, n4, n5, n6, n7;

  // n4 = XNOR(a,b) from the classic four-NOR cell.
  assign n1 = ~(a | b);
  assign n2 = ~(a | n1);
  assign n3 = ~(b | n1);
  assign n4 = ~(n2 | n3);

  // Second cell: XNOR(XNOR(a,b), c_in) = a ^ b ^ c_in.
  assign n5 = ~(n4 | c_in);
  assign n6 = ~(n4 | n5);
  assign n7 = ~(c_in | n5);
  assign sum = ~(n6 | n7);

  // carry = (a|b) & ~((a^b) & ~c_in), reusing n1 and n5.
  assign carry = ~(n1 | n5);

endmodule

// File: rtl/serial_adder_nor.sv
// Bit-serial adder, LSB first, one NOR full adder per cycle; reports carry and signed overflow.
// Latency: result valid WIDTH edges after the accept edge.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module serial_adder_nor
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             busy
);

  localparam int            CW         = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MSB_IN_CNT = CW'(WIDTH - 2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic fa_sum, fa_carry;

  fa_nor u_fa (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .c_in  (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // Next-state and datapath: load on accept, one bit per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        carry_d = fa_carry;
        // Carry out of bit WIDTH-2 is the carry into the MSB.
        if (cnt_q == MSB_IN_CNT) begin
          cmsb_d = fa_carry;
        end
        if (cnt_q == LAST_CNT) begin
          // Counter parks at WIDTH-1 rather than wrapping.
          c_out_d = fa_carry;
          ovf_d   = cmsb_q ^ fa_carry;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder_nor.sv
// Directed and random checks of serial_adder_nor at WIDTH=8 and WIDTH=16.
// Latency: n/a.
// Backpressure: random out_ready stalls in the random phase.
module tb_serial_adder_nor;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic        in_valid8 = 0, in_ready8, cin8 = 0, out_valid8, out_ready8 = 0;
  logic        c_out8, ovf8, busy8;
  logic [7:0]  a8 = '0, b8 = '0, sum8;

  logic        in_valid16 = 0, in_ready16, cin16 = 0, out_valid16, out_ready16 = 0;
  logic        c_out16, ovf16, busy16;
  logic [15:0] a16 = '0, b16 = '0, sum16;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_adder_nor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .c_in(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .c_out(c_out8), .overflow(ovf8), .busy(busy8)
  );

  serial_adder_nor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .c_in(cin16), .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .c_out(c_out16), .overflow(ovf16), .busy(busy16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one 8-bit operation and wait for its result; lat counts edges after accept.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                     output logic [7:0] s, output logic co, output logic ov, output int lat);
    int n;
    n = 0;
    while (!in_ready8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("op8_in_ready", in_ready8, 1);
    a8 = ta; b8 = tb_; cin8 = tc; in_valid8 = 1;
    @(negedge clk);
    in_valid8 = 0;
    chk("op8_busy", busy8, 1);
    lat = 0;
    while (!out_valid8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    s = sum8; co = c_out8; ov = ovf8;
  endtask

  task automatic hs8();
    out_ready8 = 1;
    @(negedge clk);
    out_ready8 = 0;
  endtask

  // a, b, c_in, sum, c_out, overflow
  logic [7:0] va [6] = '{8'hFF, 8'h7F, 8'h00, 8'h80, 8'hA5, 8'h3C};
  logic [7:0] vb [6] = '{8'h01, 8'h01, 8'h00, 8'h80, 8'h5A, 8'h4B};
  logic       vc [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
  logic [7:0] vs [6] = '{8'h00, 8'h80, 8'h01, 8'h00, 8'h00, 8'h87};
  logic       vco[6] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
  logic       vov[6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};

  initial begin
    logic [7:0] s;
    logic       co, ov;
    int         lat;
    int         n;

    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready8, 1);
    chk("rst_out_valid", out_valid8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_c_out", c_out8, 0);
    chk("rst_overflow", ovf8, 0);
    chk("rst_sum16", sum16, 0);
    rst_n = 1;

    // Directed vectors; result must appear exactly 8 edges after accept.
    for (int i = 0; i < 6; i++) begin
      op8(va[i], vb[i], vc[i], s, co, ov, lat);
      chk("dir_latency", lat, 8);
      chk("dir_sum", s, vs[i]);
      chk("dir_c_out", co, vco[i]);
      chk("dir_overflow", ov, vov[i]);
      hs8();
      chk("dir_idle_ready", in_ready8, 1);
      chk("dir_idle_sum_hold", sum8, vs[i]);
      chk("dir_idle_c_out_hold", c_out8, vco[i]);
    end

    // Back-pressure in DONE with a competing request on the inputs.
    op8(8'h55, 8'h0F, 1'b0, s, co, ov, lat);
    chk("bp_first_sum", s, 8'h64);
    a8 = 8'h11; b8 = 8'h22; cin8 = 0; in_valid8 = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_sum_stable", sum8, 8'h64);
      chk("bp_in_ready", in_ready8, 0);
      chk("bp_out_valid", out_valid8, 1);
    end
    out_ready8 = 1;
    @(negedge clk);
    out_ready8 = 0;
    chk("bp_ready_after_hs", in_ready8, 1);
    chk("bp_valid_after_hs", out_valid8, 0);
    @(negedge clk);
    in_valid8 = 0;
    chk("bp_second_accept", busy8, 1);
    n = 0;
    while (!out_valid8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_second_sum", sum8, 8'h33);
    hs8();

    // Reset in the middle of RUN aborts without delivering a result.
    a8 = 8'hAA; b8 = 8'h55; cin8 = 0; in_valid8 = 1;
    @(negedge clk);
    in_valid8 = 0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before", busy8, 1);
    rst_n = 0;
    #1;
    chk("abort_out_valid", out_valid8, 0);
    chk("abort_sum", sum8, 0);
    chk("abort_in_ready", in_ready8, 1);
    chk("abort_busy", busy8, 0);
    @(negedge clk);
    rst_n = 1;
    op8(8'h12, 8'h34, 1'b0, s, co, ov, lat);
    chk("post_rst_latency", lat, 8);
    chk("post_rst_sum", s, 8'h46);
    chk("post_rst_c_out", co, 0);
    hs8();

    // Random operands on both widths concurrently with random back-pressure.
    fork
      begin
        logic [7:0] ra, rb, rs;
        logic       rc, rco, rov;
        logic [8:0] ref9;
        int         rl;
        for (int i = 0; i < 1000; i++) begin
          ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
          op8(ra, rb, rc, rs, rco, rov, rl);
          ref9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
          repeat ($urandom_range(0, 3)) @(negedge clk);
          chk("rnd8_sum_cout", {c_out8, sum8}, ref9);
          chk("rnd8_ovf", ovf8, (ra[7] == rb[7]) && (ref9[7] != ra[7]));
          hs8();
        end
      end
      begin
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] ref17;
        int          k;
        for (int i = 0; i < 1000; i++) begin
          ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
          k = 0;
          while (!in_ready16 && k < 50) begin
            @(negedge clk);
            k++;
          end
          a16 = ra; b16 = rb; cin16 = rc; in_valid16 = 1;
          @(negedge clk);
          in_valid16 = 0;
          k = 0;
          while (!out_valid16 && k < 100) begin
            @(negedge clk);
            k++;
          end
          chk("rnd16_latency", k, 16);
          ref17 = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
          repeat ($urandom_range(0, 3)) @(negedge clk);
          chk("rnd16_sum_cout", {c_out16, sum16}, ref17);
          chk("rnd16_ovf", ovf16, (ra[15] == rb[15]) && (ref17[15] != ra[15]));
          out_ready16 = 1;
          @(negedge clk);
          out_ready16 = 0;
        end
      end
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder_nor.md
SERIAL_ADDER_NOR -- requirements
Module: serial_adder_nor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands a, b and c_in are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 The block SHALL have port a, input, WIDTH bits: augend.
REQ-007 The block SHALL have port b, input, WIDTH bits: addend.
REQ-008 The block SHALL have port c_in, input, 1 bit: carry-in.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: (a+b+c_in) mod 2^WIDTH.
REQ-012 The block SHALL have port c_out, output, 1 bit: unsigned carry-out.
REQ-013 The block SHALL have port overflow, output, 1 bit: two's-complement overflow.
REQ-014 The block SHALL have port busy, output, 1 bit: high in RUN state.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE, busy 1 only in RUN, and out_valid 1 only in DONE.
REQ-016 In IDLE, an edge with in_valid=1 SHALL latch a and b into shift registers, load carry from c_in, clear the bit counter and enter RUN.
REQ-017 In RUN, each cycle SHALL add bit 0 of both shift registers and the carry flop using one NOR-only full-adder instance (LSB first).
REQ-018 In RUN, the sum bit SHALL be shifted into the MSB of the sum register, both operand registers SHALL shift right, the carry SHALL be updated and the counter SHALL increment.
REQ-019 Latency: with the accept edge at edge 0, bits SHALL be processed on edges 1..WIDTH and out_valid SHALL be high from edge WIDTH onward; the FSM SHALL transition RUN->DONE when the counter reaches WIDTH-1 on that edge.
REQ-020 The carry out of the bit-(WIDTH-2) step SHALL be captured so that overflow equals carry-into-MSB XOR c_out.
REQ-021 In DONE, sum, c_out and overflow SHALL hold stable until out_valid & out_ready; that edge SHALL return the FSM to IDLE, so in_ready rises one cycle after the result handshake.
REQ-022 sum, c_out and overflow SHALL retain the last result in IDLE and SHALL change only during RUN.
REQ-023 in_valid SHALL be ignored outside IDLE, and operand inputs SHALL be sampled only on the accept edge.
REQ-024 out_ready SHALL be ignored outside DONE.
REQ-025 The counter width SHALL be $clog2(WIDTH); the counter SHALL never wrap within one operation.

Reset
REQ-026 While rst_n=0, the FSM SHALL be in IDLE and all registers, including the counter and carry flop, SHALL be 0.
REQ-027 During reset, outputs SHALL be: in_ready=1, out_valid=0, busy=0, sum=0, c_out=0, overflow=0.
REQ-028 Reset asserted mid-RUN or mid-DONE SHALL abort the operation immediately, with no result delivered.
REQ-029 After deassertion, the first accept SHALL be possible on the first rising edge.

Structure
REQ-030 A shared package serial_adder_pkg SHALL hold the state enum (IDLE/RUN/DONE), the default WIDTH constant and the counter-width function.
REQ-031 The one-bit adder SHALL be a separate sub-module fa_nor (ports a, b, c_in, sum, carry) built only from 2-input NOR assignments, mirroring the team's gate-level style.
REQ-032 All sequencing SHALL reside in serial_adder_nor.

Verification
REQ-033 WIDTH=8, a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1, overflow=0, with out_valid exactly 8 edges after accept.
REQ-034 a=8'h7F, b=8'h01, c_in=0 -> sum=8'h80, c_out=0, overflow=1.
REQ-035 a=8'h00, b=8'h00, c_in=1 -> sum=8'h01, c_out=0, overflow=0; a=8'h80, b=8'h80, c_in=0 -> sum=8'h00, c_out=1, overflow=1.
REQ-036 Hold out_ready=0 for 5 cycles in DONE, with in_valid=1 and new operands applied -> result stable, in_ready=0, second operation not accepted until one cycle after the handshake.
REQ-037 Assert rst_n=0 at bit 4 of RUN -> out_valid=0, sum=0, in_ready=1 immediately; the next operation (8'h12+8'h34) -> sum=8'h46.
REQ-038 Run 1000 random operands at WIDTH=8 and WIDTH=16 with random out_ready back-pressure -> {c_out,sum} matches a+b+c_in and overflow matches the signed reference.
